// File: rtl/stage_sequencer_pkg.sv
// Shared types for the multicycle stage sequencer:
// state encodings, stage-enable bundle and its decoder.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMACCESS = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic execute;
    logic memaccess;
    logic writeback;
  } stage_en_t;

  function automatic stage_en_t stage_enables(
    input state_e s
  );
    stage_en_t e;
    e = '0;
    case (s)
      ST_FETCH:     e.fetch     = 1'b1;
      ST_DECODE:    e.decode    = 1'b1;
      ST_EXECUTE:   e.execute   = 1'b1;
      ST_MEMACCESS: e.memaccess = 1'b1;
      ST_WRITEBACK: e.writeback = 1'b1;
      default:      e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Wait-state counter for memory handshakes.
// Flags expiry once LIMIT stall cycles have been seen.
module wait_timer #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST =
    W'(LIMIT == 0 ? 0 : LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: one-hot stage enables with
// wait states, stage skipping, halt control and bus timeout.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned SKIP_EN = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             im_ready,
  input  logic             dm_ready,
  input  logic             is_mem_op,
  input  logic             is_reg_write,
  output logic             enable_fetch,
  output logic             enable_decode,
  output logic             enable_execute,
  output logic             enable_memaccess,
  output logic             enable_writeback,
  output logic             stall,
  output logic             retired,
  output logic [CNT_W-1:0] retired_count,
  output logic             bus_error
);

  localparam bit SKIP = (SKIP_EN != 0);

  state_e           state_q;
  state_e           state_d;
  logic             mem_q;
  logic             mem_d;
  logic             wr_q;
  logic             wr_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire_c;
  logic             stall_c;
  logic             tmr_clr;
  logic             tmr_exp;
  stage_en_t        en_s;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    retire_c = 1'b0;
    stall_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run && !halt_req) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (im_ready) begin
          state_d = ST_DECODE;
        end else begin
          stall_c = 1'b1;
          if (tmr_exp) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DECODE: begin
        mem_d   = is_mem_op;
        wr_d    = is_reg_write;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (mem_q || !SKIP) begin
          state_d = ST_MEMACCESS;
        end else if (wr_q) begin
          state_d = ST_WRITEBACK;
        end else begin
          retire_c = 1'b1;
        end
      end
      ST_MEMACCESS: begin
        if (mem_q && !dm_ready) begin
          stall_c = 1'b1;
          if (tmr_exp) begin
            state_d = ST_ERROR;
          end
        end else if (wr_q || !SKIP) begin
          state_d = ST_WRITEBACK;
        end else begin
          retire_c = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        retire_c = 1'b1;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // halt is only honoured at an instruction boundary
    if (retire_c) begin
      state_d = halt_req ? ST_IDLE : ST_FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mem_q   <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      if (retire_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign tmr_clr = (state_d != state_q);

  wait_timer #(
    .W     (TMO_W),
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clear_i   (tmr_clr),
    .count_i   (stall_c),
    .expired_o (tmr_exp)
  );

  assign en_s             = stage_enables(state_q);
  assign enable_fetch     = en_s.fetch;
  assign enable_decode    = en_s.decode;
  assign enable_execute   = en_s.execute;
  assign enable_memaccess = en_s.memaccess;
  assign enable_writeback = en_s.writeback;

  // an instruction aborted by reset never reports retirement
  assign retired       = retire_c & reset;
  assign stall         = stall_c;
  assign retired_count = cnt_q;
  assign bus_error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: two instances
// (SKIP_EN=1/TIMEOUT=4/CNT_W=4 and SKIP_EN=0/CNT_W=8).
module tb_stage_sequencer;

  typedef struct {
    logic [4:0] mask;
    int         cyc;
    int         stl;
    int         cnt;
  } exp_t;

  logic       clock;
  logic [1:0] rstn;
  logic [1:0] run;
  logic [1:0] halt;
  logic [1:0] im;
  logic [1:0] dm;
  logic [1:0] mem;
  logic [1:0] wr;

  logic [4:0] en0;
  logic [4:0] en1;
  logic [1:0] stl;
  logic [1:0] ret;
  logic [1:0] berr;
  logic [3:0] cnt0;
  logic [7:0] cnt1;

  int   total;
  int   bad;
  exp_t q0[$];
  exp_t q1[$];
  int   model_cnt[2];

  int         m_busy[2];
  int         m_cyc[2];
  int         m_stl[2];
  logic [4:0] m_mask[2];
  int         m_pend[2];
  int         m_pcnt[2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  stage_sequencer #(
    .SKIP_EN(1), .TIMEOUT(4), .TMO_W(8), .CNT_W(4)
  ) u_a (
    .clock            (clock),
    .reset            (rstn[0]),
    .run              (run[0]),
    .halt_req         (halt[0]),
    .im_ready         (im[0]),
    .dm_ready         (dm[0]),
    .is_mem_op        (mem[0]),
    .is_reg_write     (wr[0]),
    .enable_fetch     (en0[4]),
    .enable_decode    (en0[3]),
    .enable_execute   (en0[2]),
    .enable_memaccess (en0[1]),
    .enable_writeback (en0[0]),
    .stall            (stl[0]),
    .retired          (ret[0]),
    .retired_count    (cnt0),
    .bus_error        (berr[0])
  );

  stage_sequencer #(
    .SKIP_EN(0), .TIMEOUT(16), .TMO_W(8), .CNT_W(8)
  ) u_b (
    .clock            (clock),
    .reset            (rstn[1]),
    .run              (run[1]),
    .halt_req         (halt[1]),
    .im_ready         (im[1]),
    .dm_ready         (dm[1]),
    .is_mem_op        (mem[1]),
    .is_reg_write     (wr[1]),
    .enable_fetch     (en1[4]),
    .enable_decode    (en1[3]),
    .enable_execute   (en1[2]),
    .enable_memaccess (en1[1]),
    .enable_writeback (en1[0]),
    .stall            (stl[1]),
    .retired          (ret[1]),
    .retired_count    (cnt1),
    .bus_error        (berr[1])
  );

  function automatic logic [4:0] get_en(int d);
    return (d == 0) ? en0 : en1;
  endfunction

  function automatic int get_cnt(int d);
    return (d == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // monitor: pops one expected record per retired pulse
  initial begin
    exp_t it;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0;
      m_pend[d] = 0;
    end
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        if (!rstn[d]) begin
          m_busy[d] = 0;
          m_pend[d] = 0;
        end else begin
          if (m_pend[d] != 0) begin
            chk($sformatf("count%0d", d),
                get_cnt(d), m_pcnt[d]);
            m_pend[d] = 0;
          end
          if (m_busy[d] == 0 && get_en(d)[4]) begin
            m_busy[d] = 1;
            m_cyc[d]  = 0;
            m_stl[d]  = 0;
            m_mask[d] = '0;
          end
          if (m_busy[d] != 0) begin
            m_cyc[d]++;
            m_mask[d] = m_mask[d] | get_en(d);
            m_stl[d] += int'(stl[d]);
            if (ret[d]) begin
              m_busy[d] = 0;
              if ((d == 0 ? q0.size() : q1.size()) == 0)
              begin
                total++;
                bad++;
                $display("FAIL unexp_retire%0d: got 1 expected 0", d);
              end else begin
                it = (d == 0) ? q0.pop_front()
                              : q1.pop_front();
                chk($sformatf("stages%0d", d),
                    int'(m_mask[d]), int'(it.mask));
                chk($sformatf("cycles%0d", d),
                    m_cyc[d], it.cyc);
                chk($sformatf("stalls%0d", d),
                    m_stl[d], it.stl);
                m_pend[d] = 1;
                m_pcnt[d] = it.cnt;
              end
            end
          end else if (ret[d]) begin
            total++;
            bad++;
            $display("FAIL stray_retire%0d: got 1 expected 0", d);
          end
        end
      end
    end
  end

  task automatic issue(int d, bit m, bit w,
                       int iw, int dw,
                       logic [4:0] xmask,
                       int xcyc, int xstl);
    exp_t it;
    int   fw;
    int   mw;
    bit   done;
    logic [4:0] e;
    model_cnt[d] = (model_cnt[d] + 1) % (d == 0 ? 16 : 256);
    it.mask = xmask;
    it.cyc  = xcyc;
    it.stl  = xstl;
    it.cnt  = model_cnt[d];
    if (d == 0) q0.push_back(it);
    else q1.push_back(it);
    mem[d]  = m;
    wr[d]   = w;
    halt[d] = 1'b0;
    run[d]  = 1'b1;
    im[d]   = 1'b1;
    dm[d]   = 1'b1;
    tick();
    chk($sformatf("run_to_fetch%0d", d),
        int'(get_en(d)), 5'b10000);
    run[d] = 1'b0;
    fw   = 0;
    mw   = 0;
    done = 0;
    for (int k = 0; k < 40; k++) begin
      e = get_en(d);
      if (e[4]) begin
        im[d] = (fw >= iw);
        fw++;
      end
      if (e[1]) begin
        dm[d] = (mw >= dw);
        mw++;
      end
      if (e[2]) halt[d] = 1'b1;
      @(negedge clock);
      if (ret[d]) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL retire_wait%0d: got none expected pulse", d);
    end
    tick();
    chk($sformatf("halt_idle%0d", d), int'(get_en(d)), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    rstn = 2'b00;
    run  = 2'b00;
    halt = 2'b00;
    im   = 2'b11;
    dm   = 2'b11;
    mem  = 2'b00;
    wr   = 2'b00;
    tick();
    tick();
    @(negedge clock);
    chk("rst_en0", int'(en0), 0);
    chk("rst_en1", int'(en1), 0);
    chk("rst_stall", int'(stl), 0);
    chk("rst_ret", int'(ret), 0);
    chk("rst_berr", int'(berr), 0);
    chk("rst_cnt0", int'(cnt0), 0);
    chk("rst_cnt1", int'(cnt1), 0);
    tick();
    rstn = 2'b11;
    tick();

    // SKIP_EN=1 vectors: mem wr im_wait dm_wait mask cyc stall
    issue(0, 0, 1, 0, 0, 5'b11101, 4, 0);
    issue(0, 1, 0, 0, 3, 5'b11110, 7, 3);
    issue(0, 0, 0, 0, 0, 5'b11100, 3, 0);
    issue(0, 1, 1, 2, 1, 5'b11111, 8, 3);
    issue(0, 0, 1, 3, 0, 5'b11101, 7, 3);
    issue(0, 1, 1, 0, 0, 5'b11111, 5, 0);
    for (int i = 0; i < 10; i++) begin
      issue(0, 0, 0, 0, 0, 5'b11100, 3, 0);
    end
    chk("wrap_cnt", int'(cnt0), 0);
    issue(0, 0, 1, 0, 0, 5'b11101, 4, 0);

    // reset while waiting in MEMACCESS
    mem[0]  = 1'b1;
    wr[0]   = 1'b1;
    dm[0]   = 1'b0;
    im[0]   = 1'b1;
    halt[0] = 1'b0;
    run[0]  = 1'b1;
    tick();
    run[0]  = 1'b0;
    halt[0] = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_mem_en", int'(en0), 5'b00010);
    chk("mid_mem_stall", int'(stl[0]), 1);
    rstn[0] = 1'b0;
    model_cnt[0] = 0;
    tick();
    chk("abort_en", int'(en0), 0);
    chk("abort_cnt", int'(cnt0), 0);
    rstn[0] = 1'b1;
    dm[0]   = 1'b1;
    tick();
    issue(0, 1, 0, 0, 0, 5'b11110, 4, 0);

    // fetch timeout with TIMEOUT=4
    im[0]   = 1'b0;
    halt[0] = 1'b0;
    run[0]  = 1'b1;
    tick();
    run[0] = 1'b0;
    tick();
    tick();
    tick();
    chk("tmo_fetch4", int'(en0), 5'b10000);
    chk("tmo_stall4", int'(stl[0]), 1);
    chk("tmo_berr4", int'(berr[0]), 0);
    tick();
    chk("err_en", int'(en0), 0);
    chk("err_berr", int'(berr[0]), 1);
    chk("err_stall", int'(stl[0]), 0);
    run[0] = 1'b1;
    im[0]  = 1'b1;
    tick();
    tick();
    tick();
    chk("err_sticky_en", int'(en0), 0);
    chk("err_sticky", int'(berr[0]), 1);
    run[0]  = 1'b0;
    rstn[0] = 1'b0;
    model_cnt[0] = 0;
    tick();
    chk("err_rst_berr", int'(berr[0]), 0);
    chk("err_rst_en", int'(en0), 0);
    rstn[0] = 1'b1;
    tick();
    issue(0, 0, 1, 0, 0, 5'b11101, 4, 0);

    // SKIP_EN=0: every stage, one cycle each unless waiting
    issue(1, 0, 0, 0, 0, 5'b11111, 5, 0);
    issue(1, 1, 1, 0, 1, 5'b11111, 6, 1);
    issue(1, 0, 1, 1, 0, 5'b11111, 6, 1);

    tick();
    tick();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
